// File: rtl/coin_payer.sv
// coin_payer
//   Customer-side driver for the vending automat coin interface. For a
//   requested amount it pays with one-cycle coin pulses, greedy and largest
//   coin first. It then waits for the automat's cola pulse and adds up the
//   r1/r2 change pulses before it reports completion.
//
// Parameters
//   AMT_W    width of the amount and change counters (unsigned)
//   GAP      idle cycles, with all coins low, after each coin pulse (>=1)
//   TIMEOUT  cycles spent waiting for cola before giving up (>=1)
//   SETTLE   cycles after cola that are still used to collect change (>=0)
//
// Ports
//   clk      clock; every register updates on the rising edge
//   reset    synchronous, active-high
//   start    payment request; accepted only while idle
//   amount   sum to pay; sampled on the edge that accepts start
//   cola     vend pulse from the automat
//   r1, r2   change pulses from the automat, worth 1 and 2
//   b1/b5/b10  coin pulses to the automat
//   busy     high in every state except idle
//   done     one-cycle completion pulse
//   err      failure flag, valid with done; held until the next accepted start
//   change   total change received; held until the next accepted start
module coin_payer #(
    parameter int AMT_W   = 6,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 16,
    parameter int SETTLE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             cola,
    input  logic             r1,
    input  logic             r2,
    output logic             b1,
    output logic             b5,
    output logic             b10,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] change
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COIN,
        S_GAP,
        S_WAIT,
        S_SETTLE,
        S_DONE
    } state_t;

    // One counter is shared by the GAP, WAIT and SETTLE phases, so it is
    // sized for the longest of them.
    localparam int CNT_MAX0 = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > SETTLE) ? CNT_MAX0 : SETTLE;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    localparam logic [AMT_W-1:0] VAL_1  = AMT_W'(1);
    localparam logic [AMT_W-1:0] VAL_5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_10 = AMT_W'(10);

    state_t           state;
    state_t           state_next;
    state_t           after_coins;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] coin_val;
    logic [CNT_W-1:0] cnt;
    logic             vend;
    logic             set_err;

    // Adds the change increment (0..3) to the total, clamping at all-ones.
    function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] acc,
                                                 input logic [1:0]       inc);
        logic [AMT_W:0] sum;
        sum = {1'b0, acc} + (AMT_W+1)'(inc);
        return sum[AMT_W] ? {AMT_W{1'b1}} : sum[AMT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            remaining <= '0;
            vend      <= 1'b0;
            err       <= 1'b0;
            change    <= '0;
        end else begin
            state <= state_next;
            // The counter restarts from 0 whenever a phase is entered.
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;

            if (state == S_IDLE) begin
                if (start) begin
                    remaining <= amount;
                    change    <= '0;
                    err       <= set_err;
                    vend      <= 1'b0;
                end
            end else begin
                // {r2, r1} read as a 2-bit number is r1*1 + r2*2.
                change <= sat_add(change, {r2, r1});
                if (state == S_COIN)
                    remaining <= remaining - coin_val;
                if (cola && (state == S_COIN || state == S_GAP))
                    vend <= 1'b1;
                if (set_err)
                    err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        b1          = 1'b0;
        b5          = 1'b0;
        b10         = 1'b0;
        coin_val    = '0;
        set_err     = 1'b0;
        // A cola in the final GAP cycle counts as well, so the WAIT phase is
        // skipped in that case too.
        after_coins = (vend || cola) ? ((SETTLE == 0) ? S_DONE : S_SETTLE) : S_WAIT;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (amount != '0) begin
                        state_next = S_COIN;
                    end else begin
                        state_next = S_DONE;
                        set_err    = 1'b1;
                    end
                end
            end
            S_COIN: begin
                if (remaining >= VAL_10) begin
                    b10      = 1'b1;
                    coin_val = VAL_10;
                end else if (remaining >= VAL_5) begin
                    b5       = 1'b1;
                    coin_val = VAL_5;
                end else begin
                    b1       = 1'b1;
                    coin_val = VAL_1;
                end
                state_next = S_GAP;
            end
            S_GAP: begin
                if (cnt == GAP_LAST)
                    state_next = (remaining != '0) ? S_COIN : after_coins;
            end
            S_WAIT: begin
                // cola takes priority over the timeout on the last WAIT cycle.
                if (cola) begin
                    state_next = (SETTLE == 0) ? S_DONE : S_SETTLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = S_DONE;
                    set_err    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST)
                    state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
